// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the bin2bcd_seq converter.
// The master side requests conversions; the slave side is the converter itself.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (output start, output bin, input busy, input done, input bcd, input blank);
  modport slave  (input start, input bin, output busy, output done, output bcd, output blank);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic          clock,
  input  logic          resetn,
  bin2bcd_seq_if.slave  bus
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + WIDTH;
  localparam int CNT_W  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_next;
  logic [WORK_W-1:0]   work, work_next, adjusted, shifted;
  logic [CNT_W-1:0]    count, count_next;
  logic [BCD_W-1:0]    bcd_q, bcd_next;
  logic                done_q, done_next;

  // Add-3 correction on the pre-shift BCD nibbles, then the single left shift.
  always_comb begin
    adjusted = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[WIDTH+4*i +: 4] >= 4'd5)
        adjusted[WIDTH+4*i +: 4] = work[WIDTH+4*i +: 4] + 4'd3;
    end
    shifted = adjusted << 1;
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    count_next = count;
    bcd_next   = bcd_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          work_next  = {{BCD_W{1'b0}}, bus.bin};
          count_next = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        work_next  = shifted;
        count_next = count + CNT_W'(1);
        if (count == CNT_W'(WIDTH - 1)) begin
          bcd_next   = shifted[WORK_W-1 -: BCD_W];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      count  <= count_next;
      bcd_q  <= bcd_next;
      done_q <= done_next;
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_next;
  logic              seen;

  // Blank every digit above the most-significant non-zero one; digit 0 always shows.
  always_comb begin
    blank_next = '0;
    seen       = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (shifted[WIDTH+4*i +: 4] != 4'd0)
        seen = 1'b1;
      blank_next[i] = ~seen;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      blank_q <= '0;
    else if (done_next)
      blank_q <= blank_next;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

endmodule
